// File: rtl/arbiter_mux5.sv
// arbiter_mux5: five-to-one merging arbiter with a single registered output slot.
// Picks one of five valid/ready sources per cycle and presents the word together
// with its 3-bit source index so a downstream demultiplexer can route responses.
// Optional feature macro ARBITER_MUX5_RR_EN: when defined the arbiter is round-robin
// with a rotating pointer; when undefined it is fixed priority (source 0 highest).
module arbiter_mux5 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [4:0]       in_valid,
    output logic [4:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_e;

    slotState_e       slot_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       sel_q;

    logic             load;
    logic             anyReq;
    logic             found;
    logic [2:0]       winner;
    logic [3:0]       idx;
    logic [2:0]       ptrEff;
    logic [2:0]       ptr_d;
    logic [WIDTH-1:0] selData;

`ifdef ARBITER_MUX5_RR_EN
    logic [2:0] ptr_q;

    // Out-of-range pointer values cannot arise in operation; if one is forced,
    // scanning starts at source 0 as if the pointer had wrapped.
    assign ptrEff = (ptr_q > 3'd4) ? 3'd0 : ptr_q;
`else
    assign ptrEff = 3'd0;
`endif

    assign load   = (slot_q == EMPTY) || out_ready;
    assign anyReq = |in_valid;
    assign ptr_d  = (winner == 3'd4) ? 3'd0 : winner + 3'd1;

    // Scan requests starting at the pointer and wrapping modulo five; first hit wins.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, ptrEff} + 4'(k);
            if (idx >= 4'd5) begin
                idx = idx - 4'd5;
            end
            if (!found && in_valid[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    // Route the winning source's data toward the output slot.
    always_comb begin
        selData = in0;
        case (winner)
            3'd1:    selData = in1;
            3'd2:    selData = in2;
            3'd3:    selData = in3;
            3'd4:    selData = in4;
            default: selData = in0;
        endcase
    end

    // Grant is one-hot to the winner only when the slot can take a word; held low in reset.
    always_comb begin
        in_ready = 5'b00000;
        if (rst_n && load && anyReq) begin
            in_ready = 5'b00001 << winner;
        end
    end

    // Output slot: load on grant (replacing any word being popped), empty when nothing arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= EMPTY;
            data_q <= '0;
            sel_q  <= 3'd0;
        end else if (load) begin
            if (anyReq) begin
                slot_q <= FULL;
                data_q <= selData;
                sel_q  <= winner;
            end else begin
                slot_q <= EMPTY;
            end
        end
    end

`ifdef ARBITER_MUX5_RR_EN
    // Rotate the priority pointer to just past each granted source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else if (load && anyReq) begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unusedPtr;
    assign unusedPtr = ^ptr_d;
`endif

    assign out       = data_q;
    assign out_sel   = sel_q;
    assign out_valid = (slot_q == FULL);

endmodule

// File: tb/tb_arbiter_mux5.sv
// tb_arbiter_mux5: directed-vector bench for arbiter_mux5 at WIDTH=8.
// Expected grants depend on ARBITER_MUX5_RR_EN, matching whichever build is compiled.
module tb_arbiter_mux5;

    localparam int WIDTH = 8;

`ifdef ARBITER_MUX5_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in0, in1, in2, in3, in4;
    logic [4:0]       in_valid;
    logic [4:0]       in_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    int compareCount;
    int mismatchCount;

    logic [7:0] inData [5];

    arbiter_mux5 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the request vector and sink ready, then let combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
        #1;
    endtask

    initial begin
        logic [2:0] expSel;
        compareCount  = 0;
        mismatchCount = 0;

        inData[0] = 8'h10;
        inData[1] = 8'h21;
        inData[2] = 8'hA5;
        inData[3] = 8'h43;
        inData[4] = 8'h54;
        in0 = inData[0];
        in1 = inData[1];
        in2 = inData[2];
        in3 = inData[3];
        in4 = inData[4];

        rst_n     = 1'b0;
        in_valid  = 5'b00000;
        out_ready = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out", 32'(out), 32'd0);
        checkOutput("rst_sel", 32'(out_sel), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Single source 2
        applyStimulus(5'b00100, 1'b1);
        checkOutput("single_ready", 32'(in_ready), 32'b00100);
        stepCycle();
        checkOutput("single_out", 32'(out), 32'hA5);
        checkOutput("single_sel", 32'(out_sel), 32'd2);
        checkOutput("single_valid", 32'(out_valid), 32'd1);

        // Drain: slot empties but data/index hold
        applyStimulus(5'b00000, 1'b1);
        checkOutput("drain_ready", 32'(in_ready), 32'd0);
        stepCycle();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_out", 32'(out), 32'hA5);
        checkOutput("drain_sel", 32'(out_sel), 32'd2);

        // Load a word, then reset asynchronously mid-cycle
        applyStimulus(5'b00010, 1'b1);
        checkOutput("load_ready", 32'(in_ready), 32'b00010);
        stepCycle();
        checkOutput("load_sel", 32'(out_sel), 32'd1);
        checkOutput("load_valid", 32'(out_valid), 32'd1);
        rst_n    = 1'b0;
        in_valid = 5'b11111;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out", 32'(out), 32'd0);
        checkOutput("midrst_sel", 32'(out_sel), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;

        // All five requesting for ten cycles
        for (int i = 0; i < 10; i++) begin
            expSel = RR ? 3'(i % 5) : 3'd0;
            applyStimulus(5'b11111, 1'b1);
            checkOutput("all_ready", 32'(in_ready), 32'(5'b00001 << expSel));
            stepCycle();
            checkOutput("all_sel", 32'(out_sel), 32'(expSel));
            checkOutput("all_valid", 32'(out_valid), 32'd1);
            checkOutput("all_out", 32'(out), 32'(inData[expSel]));
        end

        // One grant to source 2 moves the pointer to 3 in round-robin
        applyStimulus(5'b00100, 1'b1);
        checkOutput("pre_bp_ready", 32'(in_ready), 32'b00100);
        stepCycle();
        checkOutput("pre_bp_sel", 32'(out_sel), 32'd2);

        // Backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b11111, 1'b0);
            checkOutput("bp_ready", 32'(in_ready), 32'd0);
            stepCycle();
            checkOutput("bp_sel", 32'(out_sel), 32'd2);
            checkOutput("bp_out", 32'(out), 32'hA5);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
        end

        // Release: grant follows the pointer
        expSel = RR ? 3'd3 : 3'd0;
        applyStimulus(5'b11111, 1'b1);
        checkOutput("release_ready", 32'(in_ready), 32'(5'b00001 << expSel));
        stepCycle();
        checkOutput("release_sel", 32'(out_sel), 32'(expSel));
        checkOutput("release_out", 32'(out), 32'(inData[expSel]));

        // Wrap from pointer 4 back to source 0, then source 0 again with gaps
        applyStimulus(5'b00011, 1'b1);
        checkOutput("wrap_ready", 32'(in_ready), 32'b00001);
        stepCycle();
        checkOutput("wrap_sel", 32'(out_sel), 32'd0);
        checkOutput("wrap_out", 32'(out), 32'h10);
        applyStimulus(5'b00001, 1'b1);
        checkOutput("gap_ready", 32'(in_ready), 32'b00001);
        stepCycle();
        checkOutput("gap_sel", 32'(out_sel), 32'd0);
        checkOutput("gap_valid", 32'(out_valid), 32'd1);

        // Final drain
        applyStimulus(5'b00000, 1'b1);
        stepCycle();
        checkOutput("final_valid", 32'(out_valid), 32'd0);
        checkOutput("final_sel", 32'(out_sel), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
